// File: rtl/program_loader_if.sv
// Byte-stream ingress and packed memory request/response bus between the loader and its environment.
// master = loader side; slave = stream source plus program memory.
interface program_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] memory_in;
    logic [7:0]  memory_out;

    modport master (
        input  in_data,
        input  in_valid,
        input  memory_out,
        output in_ready,
        output memory_in
    );

    modport slave (
        output in_data,
        output in_valid,
        output memory_out,
        input  in_ready,
        input  memory_in
    );
endinterface

// File: rtl/program_loader.sv
// Preloads the 16x8 program memory from a byte stream, optionally reads it back against a checksum.
// Latency: one registered write per accepted beat; each readback costs READ_LATENCY+1 cycles, plus one CHECK cycle.
// Backpressure: in_ready is high only in LOAD; bytes offered in any other state are left unconsumed.
module program_loader #(
    parameter logic [2:0] CTRL_IDLE    = 3'b000,
    parameter logic [2:0] CTRL_WRITE   = 3'b001,
    parameter logic [2:0] CTRL_READ    = 3'b010,
    parameter int         READ_LATENCY = 1,
    parameter bit         VERIFY_EN    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    program_loader_if.master   bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cpu_rst_n,
    output logic [7:0]         checksum
);

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] addr;
        logic [2:0] ctrl;
    } mem_req_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        V_REQ,
        V_WAIT,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_t     state_q, state_d;
    mem_req_t   req_q, req_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] vaddr_q, vaddr_d;
    logic [1:0] lat_q, lat_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] chk_q, chk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '{data: 8'h00, addr: 4'h0, ctrl: CTRL_IDLE};
            cnt_q   <= '0;
            vaddr_q <= '0;
            lat_q   <= '0;
            sum_q   <= '0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            vaddr_q <= vaddr_d;
            lat_q   <= lat_d;
            sum_q   <= sum_d;
            chk_q   <= chk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vaddr_d     = vaddr_q;
        lat_d       = lat_q;
        sum_d       = sum_q;
        chk_d       = chk_q;
        // Requests are one-cycle strobes; data/addr are held to keep the bus quiet.
        req_d       = req_q;
        req_d.ctrl  = CTRL_IDLE;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    vaddr_d = '0;
                    lat_d   = '0;
                    sum_d   = '0;
                    chk_d   = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    req_d = '{data: bus.in_data, addr: cnt_q[3:0], ctrl: CTRL_WRITE};
                    chk_d = chk_q + bus.in_data;
                    cnt_d = cnt_q + 5'd1;
                    // cnt[4] marks the 16th beat; the address can never wrap.
                    if (cnt_d[4]) begin
                        state_d = VERIFY_EN ? V_REQ : DONE;
                    end
                end
            end
            V_REQ: begin
                req_d   = '{data: 8'h00, addr: vaddr_q, ctrl: CTRL_READ};
                lat_d   = '0;
                state_d = V_WAIT;
            end
            V_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    sum_d   = sum_q + bus.memory_out;
                    vaddr_d = vaddr_q + 4'd1;
                    state_d = (vaddr_q == 4'hF) ? CHECK : V_REQ;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            CHECK: begin
                state_d = (sum_q == chk_q) ? DONE : ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.memory_in = req_q;
    assign busy          = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign done          = (state_q == DONE);
    assign error         = (state_q == ERROR);
    assign cpu_rst_n     = (state_q == DONE);
    assign checksum      = chk_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench: three loaders (default, no verify, read latency 3) share one byte stream;
// writes/reads are checked by a negedge monitor, status samples are queued for it to compare.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic corrupt7 = 1'b0;

    always #5 clk = ~clk;

    program_loader_if bus0();
    program_loader_if bus1();
    program_loader_if bus2();

    logic       busy0, done0, error0, cpu0;
    logic       busy1, done1, error1, cpu1;
    logic       busy2, done2, error2, cpu2;
    logic [7:0] cs0, cs1, cs2;

    program_loader u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
        .busy(busy0), .done(done0), .error(error0), .cpu_rst_n(cpu0), .checksum(cs0)
    );

    program_loader #(.VERIFY_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
        .busy(busy1), .done(done1), .error(error1), .cpu_rst_n(cpu1), .checksum(cs1)
    );

    program_loader #(.READ_LATENCY(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus2),
        .busy(busy2), .done(done2), .error(error2), .cpu_rst_n(cpu2), .checksum(cs2)
    );

    // Memory models: u0 has combinational read (latency 1), u2 adds two register stages.
    logic [7:0] mem0 [16];
    logic [7:0] mem2 [16];
    logic [7:0] d1, d2;

    always @(posedge clk) begin
        if (bus0.memory_in[2:0] == 3'b001) mem0[bus0.memory_in[6:3]] <= bus0.memory_in[14:7];
        if (bus2.memory_in[2:0] == 3'b001) mem2[bus2.memory_in[6:3]] <= bus2.memory_in[14:7];
        d1 <= mem2[bus2.memory_in[6:3]];
        d2 <= d1;
    end

    assign bus0.memory_out = (corrupt7 && bus0.memory_in[6:3] == 4'd7) ? 8'h00 : mem0[bus0.memory_in[6:3]];
    assign bus1.memory_out = 8'h00;
    assign bus2.memory_out = d2;

    logic [14:0] exp_wr [$];
    string       sq_name [$];
    logic [31:0] sq_act [$];
    logic [31:0] sq_exp [$];
    int          checks = 0;
    int          failures = 0;

    task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        sq_name.push_back(nm);
        sq_act.push_back(act);
        sq_exp.push_back(exp);
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        bus0.in_valid = v; bus1.in_valid = v; bus2.in_valid = v;
        bus0.in_data  = d; bus1.in_data  = d; bus2.in_data  = d;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // n beats of base + i*step; optional idle cycle after each beat; start raised alongside beat sp.
    task automatic send(input logic [7:0] base, input logic [7:0] step, input int n,
                        input bit gaps, input int sp);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i) * step;
            drive(1'b1, b);
            start = (i == sp);
            exp_wr.push_back({b, 4'(i), 3'b001});
            @(posedge clk); #1;
            start = 1'b0;
            if (gaps && i < n - 1) begin
                drive(1'b0, 8'hAA);
                @(posedge clk); #1;
                expect_eq("gap_ctrl", 32'(bus0.memory_in[2:0]), 32'd0);
            end
        end
        drive(1'b0, 8'h00);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (n < 300 && (busy0 || busy1 || busy2)) begin
            @(negedge clk);
            n++;
        end
        expect_eq("wait_end_busy", 32'(busy0 | busy1 | busy2), 32'd0);
    endtask

    // Monitor: drains queued status samples and scoreboards every write/read strobe.
    initial begin : monitor
        int cyc, rd0, rd2, last0, last2;
        logic [14:0] w;
        logic [31:0] a, e;
        string nm;
        cyc = 0; rd0 = 0; rd2 = 0; last0 = 0; last2 = 0;
        forever begin
            @(negedge clk);
            cyc++;
            while (sq_name.size() > 0) begin
                nm = sq_name.pop_front();
                a  = sq_act.pop_front();
                e  = sq_exp.pop_front();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got %0h expected %0h", nm, a, e);
                end
            end
            if (bus0.memory_in[2:0] == 3'b001) begin
                checks++;
                if (bus0.memory_in[6:3] == 4'd0) rd0 = 0;
                if (exp_wr.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected: got %0h expected none", bus0.memory_in);
                end else begin
                    w = exp_wr.pop_front();
                    if (bus0.memory_in !== w) begin
                        failures++;
                        $display("FAIL wr: got %0h expected %0h", bus0.memory_in, w);
                    end
                end
            end
            if (bus0.memory_in[2:0] == 3'b010) begin
                checks++;
                w = {8'h00, 4'(rd0), 3'b010};
                if (bus0.memory_in !== w) begin
                    failures++;
                    $display("FAIL rd0_req: got %0h expected %0h", bus0.memory_in, w);
                end
                if (rd0 > 0) begin
                    checks++;
                    if (cyc - last0 != 2) begin
                        failures++;
                        $display("FAIL rd0_spacing: got %0d expected 2", cyc - last0);
                    end
                end
                last0 = cyc;
                rd0++;
            end
            if (bus2.memory_in[2:0] == 3'b001 && bus2.memory_in[6:3] == 4'd0) rd2 = 0;
            if (bus2.memory_in[2:0] == 3'b010) begin
                if (rd2 > 0) begin
                    checks++;
                    if (cyc - last2 != 4) begin
                        failures++;
                        $display("FAIL rd2_spacing: got %0d expected 4", cyc - last2);
                    end
                end
                last2 = cyc;
                rd2++;
            end
        end
    end

    initial begin : stimulus
        int t0, t1, t2;

        // Reset with start and in_valid held high.
        drive(1'b1, 8'h55);
        start = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        expect_eq("rst_memory_in", 32'(bus0.memory_in), 32'h0);
        expect_eq("rst_in_ready", 32'(bus0.in_ready), 32'd0);
        expect_eq("rst_busy", 32'(busy0), 32'd0);
        expect_eq("rst_done", 32'(done0), 32'd0);
        expect_eq("rst_error", 32'(error0), 32'd0);
        expect_eq("rst_cpu_rst_n", 32'(cpu0), 32'd0);
        expect_eq("rst_checksum", 32'(cs0), 32'h0);
        @(posedge clk); #1;
        start = 1'b0;
        drive(1'b0, 8'h00);
        rst_n = 1'b1;

        // Clean load 0x10..0x1F: sum 0x178 -> 0x78.
        pulse_start();
        expect_eq("load_cpu_rst_n", 32'(cpu0), 32'd0);
        send(8'h10, 8'h01, 16, 1'b0, -1);
        t0 = 0; t1 = 0; t2 = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) expect_eq("in_ready_after_load", 32'(bus0.in_ready), 32'd0);
            if (done0 && t0 == 0) t0 = n;
            if (done1 && t1 == 0) t1 = n;
            if (done2 && t2 == 0) t2 = n;
            if (t0 != 0 && t1 != 0 && t2 != 0) break;
        end
        expect_eq("done_cycle_lat1", 32'(t0), 32'd34);
        expect_eq("done_cycle_noverify", 32'(t1), 32'd1);
        expect_eq("done_cycle_lat3", 32'(t2), 32'd66);
        expect_eq("clean_checksum", 32'(cs0), 32'h78);
        expect_eq("clean_checksum_noverify", 32'(cs1), 32'h78);
        expect_eq("clean_checksum_lat3", 32'(cs2), 32'h78);
        expect_eq("clean_cpu_rst_n", 32'(cpu0), 32'd1);
        expect_eq("clean_error", 32'(error0), 32'd0);

        // Bytes offered in DONE must be ignored.
        @(posedge clk); #1;
        drive(1'b1, 8'h77);
        repeat (3) @(posedge clk);
        #1 drive(1'b0, 8'h00);
        @(negedge clk);
        expect_eq("done_ignores_stream", 32'(cs0), 32'h78);
        expect_eq("done_held", 32'(done0), 32'd1);

        // Gapped 0xFF stream, with a stray start on beat 5: sum 0xFF0 -> 0xF0.
        pulse_start();
        send(8'hFF, 8'h00, 16, 1'b1, 5);
        wait_end();
        expect_eq("gap_checksum", 32'(cs0), 32'hF0);
        expect_eq("gap_done", 32'(done0), 32'd1);

        // Address 7 reads back as 0x00 on u0.
        corrupt7 = 1'b1;
        pulse_start();
        send(8'h10, 8'h01, 16, 1'b0, -1);
        wait_end();
        expect_eq("corrupt_error", 32'(error0), 32'd1);
        expect_eq("corrupt_done", 32'(done0), 32'd0);
        expect_eq("corrupt_cpu_rst_n", 32'(cpu0), 32'd0);
        repeat (5) @(negedge clk);
        expect_eq("corrupt_error_held", 32'(error0), 32'd1);
        corrupt7 = 1'b0;
        pulse_start();
        expect_eq("restart_error_clear", 32'(error0), 32'd0);
        send(8'h10, 8'h01, 16, 1'b0, -1);
        wait_end();
        expect_eq("recover_done", 32'(done0), 32'd1);
        expect_eq("recover_error", 32'(error0), 32'd0);
        expect_eq("recover_cpu_rst_n", 32'(cpu0), 32'd1);

        // Reset after the 9th byte, then reload 0x21..0x30: sum 0x288 -> 0x88.
        pulse_start();
        expect_eq("restart_cpu_rst_n", 32'(cpu0), 32'd0);
        send(8'h30, 8'h01, 9, 1'b0, -1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        expect_eq("abort_memory_in", 32'(bus0.memory_in), 32'h0);
        expect_eq("abort_busy", 32'(busy0), 32'd0);
        expect_eq("abort_in_ready", 32'(bus0.in_ready), 32'd0);
        expect_eq("abort_checksum", 32'(cs0), 32'h0);
        expect_eq("abort_cpu_rst_n", 32'(cpu0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_start();
        send(8'h21, 8'h01, 16, 1'b0, -1);
        wait_end();
        expect_eq("reload_checksum", 32'(cs0), 32'h88);
        expect_eq("reload_done", 32'(done0), 32'd1);

        expect_eq("wr_left", 32'(exp_wr.size()), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
